sram_2p_bw: RTL and testbench
=============================

Name: sram_2p_bw

Overview:
Parametrised synchronous two-port SRAM: one write port (A) and one read port (B) on a single clock, with per-byte write masking and read-during-write forwarding. Per-word written-status tracking flags reads of never-written locations. It generalises the fixed 32x26 two-port macros to any width, depth and byte count, and is the standard behavioural/synthesisable buffer for the DSP datapath (coefficient and delay-line storage).

Parameters:
DW, 32, data width in bits; must be divisible by NBYTE
NBYTE, 4, number of byte-write lanes; lane width BW = DW/NBYTE
AW, 5, address width
DEPTH, 32, number of words; 1 <= DEPTH <= 2^AW

Ports:
CK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
A  in  AW  write address
CSA  in  1  write-port select, active-high
WEB  in  1  write enable, active-low
BWEB  in  NBYTE  byte-write enables, active-low, bit i covers DI[i*BW +: BW]
DI  in  DW  write data
B  in  AW  read address
CSB  in  1  read-port select, active-high
OE  in  1  output enable, active-high, combinational on DO
DO  out  DW  read data
DV  out  1  read data valid
UNINIT  out  1  read word never written since reset
AERR  out  1  read or write address >= DEPTH

Behaviour:
- Reset (RST=1, asynchronous): DV=0, DO register=0, UNINIT=0, AERR=0, all per-word written bits cleared. Array contents are not cleared. Reset asserted mid-cycle discards that cycle's write and read.
- Write: on rising CK, if CSA=1, WEB=0 and A<DEPTH, every lane i with BWEB[i]=0 updates mem[A] lane i from DI. Lanes with BWEB[i]=1 keep their value. written[A] is set even if all BWEB bits are 1. The written bit is set but no data changes in that case.
- Read: on rising CK with CSB=1, the read is captured. DO, DV, UNINIT and AERR update at that edge, giving 1-cycle latency.
- If CSB=0, DV goes to 0 at the next edge and DO, UNINIT and AERR hold their last values.
- Read-during-write, same address (write active, A==B, A<DEPTH): write-through per lane. Written lanes return DI and unwritten lanes return the old contents. UNINIT=0.
- Read of a word whose written bit is clear: DO data=0, UNINIT=1, DV=1.
- Out-of-range read (B>=DEPTH): DO data=0, AERR=1, UNINIT=0, DV=1.
- Out-of-range write (A>=DEPTH): array unchanged. AERR pulses for one cycle at the next edge, ORed with the read AERR.
- OE=0: DO driven to all zeros, combinationally; the internal register is unaffected. DV, UNINIT and AERR are not gated by OE.
- Simultaneous read and write to different addresses: independent. The read returns the pre-edge contents of B.
- Width rules: no arithmetic; DW, NBYTE and DEPTH are checked at elaboration and a violation causes a fatal error.

Optional Feature:
Macro SRAM_2P_BW_OUTREG_EN.
- Defined: an extra output pipeline register is added. Read latency becomes 2 cycles, and DO, DV, UNINIT and AERR all move together through the stage. Reset clears the stage to 0. Forwarding is still evaluated at the capture edge.
- Undefined: 1-cycle latency as described in Behaviour.

Test Plan:
1. Reset then read B=3 (CSB=1, OE=1) -> next cycle DV=1, UNINIT=1, DO=0x00000000.
2. Write A=5, DI=0xA1B2C3D4, BWEB=0000; read B=5 next cycle -> DO=0xA1B2C3D4, DV=1, UNINIT=0.
3. Then write A=5, DI=0xFFFFFFFF, BWEB=1010; read B=5 -> DO=0xA1FFC3FF.
4. Same cycle: write A=7 DI=0x12345678 BWEB=1100, read B=7 (previous contents 0xCAFEBABE) -> DO=0xCAFE5678 after 1 cycle.
5. With DEPTH=20, read B=25 and write A=30 -> AERR=1, DO=0, array contents unchanged. OE=0 during a valid read -> DO=0 while DV=1.
6. Assert RST mid-burst of writes, then read previously written A=5 -> UNINIT=1, DO=0. With SRAM_2P_BW_OUTREG_EN defined, repeat case 2 -> DV asserts 2 cycles after the read.

Source files
------------

// File: rtl/sram_2p_bw.sv
// sram_2p_bw: synchronous two-port SRAM (write port A, read port B, one clock)
// with per-byte write masking, same-address write-through, per-word
// written-status tracking and out-of-range address flagging.
// Optional macro SRAM_2P_BW_OUTREG_EN adds an output pipeline register
// (read latency 2 instead of 1).
module sram_2p_bw #(
    parameter int DW    = 32,
    parameter int NBYTE = 4,
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [AW-1:0]    A,
    input  logic             CSA,
    input  logic             WEB,
    input  logic [NBYTE-1:0] BWEB,
    input  logic [DW-1:0]    DI,
    input  logic [AW-1:0]    B,
    input  logic             CSB,
    input  logic             OE,
    output logic [DW-1:0]    DO,
    output logic             DV,
    output logic             UNINIT,
    output logic             AERR
);

    localparam int BW = DW / NBYTE;

    // Geometry sanity checks, resolved at elaboration.
    if (NBYTE < 1 || (DW % NBYTE) != 0) begin : g_bad_width
        $fatal(1, "sram_2p_bw: DW must be a positive multiple of NBYTE");
    end
    if (DEPTH < 1 || DEPTH > (1 << AW)) begin : g_bad_depth
        $fatal(1, "sram_2p_bw: DEPTH must satisfy 1 <= DEPTH <= 2**AW");
    end

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] written_q;

    logic             wr_req, wr_oor, wr_ok, rd_oor, fwd;
    logic [DW-1:0]    lane_mask;
    logic [DW-1:0]    rd_word;

    logic [DW-1:0]    do_q, do_d;
    logic             dv_q, dv_d;
    logic             uninit_q, uninit_d;
    logic             rd_aerr_q, rd_aerr_d;
    logic             wr_aerr_q, wr_aerr_d;

    assign wr_req  = CSA & ~WEB;
    assign wr_oor  = ({1'b0, A} >= (AW+1)'(DEPTH));
    assign rd_oor  = ({1'b0, B} >= (AW+1)'(DEPTH));
    assign wr_ok   = wr_req & ~wr_oor;
    assign fwd     = wr_ok & (A == B);
    assign rd_word = mem[B];

    // Expand active-low byte enables into a bit mask of lanes being written.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NBYTE; i++) begin
            lane_mask[i*BW +: BW] = {BW{~BWEB[i]}};
        end
    end

    // Array write: only enabled lanes change; a write coinciding with reset is dropped.
    always_ff @(posedge CK) begin
        if (!RST && wr_ok) begin
            for (int i = 0; i < NBYTE; i++) begin
                if (!BWEB[i]) begin
                    mem[A][i*BW +: BW] <= DI[i*BW +: BW];
                end
            end
        end
    end

    // Written-status bit per word, set by any in-range write even with all lanes masked.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            written_q <= '0;
        end else if (wr_ok) begin
            written_q[A] <= 1'b1;
        end
    end

    // Read-port next state: forwarding, uninitialised and out-of-range handling.
    always_comb begin
        do_d      = do_q;
        dv_d      = 1'b0;
        uninit_d  = uninit_q;
        rd_aerr_d = rd_aerr_q;
        wr_aerr_d = wr_req & wr_oor;
        if (CSB) begin
            dv_d      = 1'b1;
            rd_aerr_d = rd_oor;
            if (rd_oor) begin
                do_d     = '0;
                uninit_d = 1'b0;
            end else if (fwd) begin
                do_d     = (DI & lane_mask) | (rd_word & ~lane_mask);
                uninit_d = 1'b0;
            end else if (!written_q[B]) begin
                do_d     = '0;
                uninit_d = 1'b1;
            end else begin
                do_d     = rd_word;
                uninit_d = 1'b0;
            end
        end
    end

    // Read-port capture registers.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            do_q      <= '0;
            dv_q      <= 1'b0;
            uninit_q  <= 1'b0;
            rd_aerr_q <= 1'b0;
            wr_aerr_q <= 1'b0;
        end else begin
            do_q      <= do_d;
            dv_q      <= dv_d;
            uninit_q  <= uninit_d;
            rd_aerr_q <= rd_aerr_d;
            wr_aerr_q <= wr_aerr_d;
        end
    end

`ifdef SRAM_2P_BW_OUTREG_EN
    logic [DW-1:0] do_p_q;
    logic          dv_p_q, uninit_p_q, aerr_p_q;

    // Extra output stage: all read outputs move together, one cycle later.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            do_p_q     <= '0;
            dv_p_q     <= 1'b0;
            uninit_p_q <= 1'b0;
            aerr_p_q   <= 1'b0;
        end else begin
            do_p_q     <= do_q;
            dv_p_q     <= dv_q;
            uninit_p_q <= uninit_q;
            aerr_p_q   <= rd_aerr_q | wr_aerr_q;
        end
    end

    assign DO     = OE ? do_p_q : '0;
    assign DV     = dv_p_q;
    assign UNINIT = uninit_p_q;
    assign AERR   = aerr_p_q;
`else
    assign DO     = OE ? do_q : '0;
    assign DV     = dv_q;
    assign UNINIT = uninit_q;
    assign AERR   = rd_aerr_q | wr_aerr_q;
`endif

endmodule

// File: tb/tb_sram_2p_bw.sv
// Self-checking bench for sram_2p_bw (DEPTH=20 so out-of-range addresses exist).
module tb_sram_2p_bw;
    localparam int DW    = 32;
    localparam int NBYTE = 4;
    localparam int AW    = 5;
    localparam int DEPTH = 20;
`ifdef SRAM_2P_BW_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             CK;
    logic             RST;
    logic [AW-1:0]    A, B;
    logic             CSA, WEB, CSB, OE;
    logic [NBYTE-1:0] BWEB;
    logic [DW-1:0]    DI;
    logic [DW-1:0]    DO;
    logic             DV, UNINIT, AERR;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    sram_2p_bw #(.DW(DW), .NBYTE(NBYTE), .AW(AW), .DEPTH(DEPTH)) dut (
        .CK(CK), .RST(RST), .A(A), .CSA(CSA), .WEB(WEB), .BWEB(BWEB), .DI(DI),
        .B(B), .CSB(CSB), .OE(OE), .DO(DO), .DV(DV), .UNINIT(UNINIT), .AERR(AERR)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory, written flags, and expected outputs after
    // one capture edge (e1_*) and after an extra stage (e2_*).
    logic [31:0] m_mem [32];
    bit          m_wr  [32];
    logic [31:0] e1_do, e2_do;
    bit          e1_dv, e1_un, e1_raerr, e1_waerr;
    bit          e2_dv, e2_un, e2_aerr;

    always @(posedge CK or posedge RST) begin
        logic [31:0] rd;
        int a, b;
        bit wok;
        if (RST) begin
            for (int i = 0; i < 32; i++) m_wr[i] = 0;
            e1_do = 0; e1_dv = 0; e1_un = 0; e1_raerr = 0; e1_waerr = 0;
            e2_do = 0; e2_dv = 0; e2_un = 0; e2_aerr = 0;
        end else begin
            e2_do = e1_do; e2_dv = e1_dv; e2_un = e1_un; e2_aerr = e1_raerr | e1_waerr;
            a = int'(A);
            b = int'(B);
            wok = CSA && !WEB && a < DEPTH;
            if (CSB) begin
                e1_dv    = 1;
                e1_raerr = (b >= DEPTH);
                if (b >= DEPTH) begin
                    e1_do = 0; e1_un = 0;
                end else if (wok && a == b) begin
                    rd = m_mem[b];
                    for (int l = 0; l < NBYTE; l++) if (!BWEB[l]) rd[l*8 +: 8] = DI[l*8 +: 8];
                    e1_do = rd; e1_un = 0;
                end else if (!m_wr[b]) begin
                    e1_do = 0; e1_un = 1;
                end else begin
                    e1_do = m_mem[b]; e1_un = 0;
                end
            end else begin
                e1_dv = 0;
            end
            e1_waerr = CSA && !WEB && a >= DEPTH;
            if (wok) begin
                for (int l = 0; l < NBYTE; l++) if (!BWEB[l]) m_mem[a][l*8 +: 8] = DI[l*8 +: 8];
                m_wr[a] = 1;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge CK) begin
        logic [31:0] xdo;
        bit xdv, xun, xae;
        if (cmp_en && !RST) begin
            if (LAT == 2) begin
                xdo = e2_do; xdv = e2_dv; xun = e2_un; xae = e2_aerr;
            end else begin
                xdo = e1_do; xdv = e1_dv; xun = e1_un; xae = e1_raerr | e1_waerr;
            end
            chk("model_DO", DO, OE ? xdo : 32'h0);
            chk("model_DV", {31'b0, DV}, {31'b0, xdv});
            chk("model_UNINIT", {31'b0, UNINIT}, {31'b0, xun});
            chk("model_AERR", {31'b0, AERR}, {31'b0, xae});
        end
    end

    task automatic idle();
        CSA = 0; WEB = 1; BWEB = '1; CSB = 0;
    endtask

    task automatic tick();
        @(posedge CK);
        #2;
    endtask

    // After a capture edge: wait out remaining latency, land on the negedge.
    task automatic settle();
        idle();
        repeat (LAT - 1) tick();
        #3;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        CSA = 1; WEB = 0; A = a; DI = d; BWEB = be;
    endtask

    task automatic rd(input logic [AW-1:0] b);
        CSB = 1; B = b;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_DO"}, DO, 32'h0);
        chk({tag, "_DV"}, {31'b0, DV}, 32'h0);
        chk({tag, "_UNINIT"}, {31'b0, UNINIT}, 32'h0);
        chk({tag, "_AERR"}, {31'b0, AERR}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1; A = 0; B = 0; DI = 0; OE = 1;
        idle();
        repeat (2) tick();
        chk_rst("reset");
        RST = 0;
        cmp_en = 1;

        // Read of never-written word
        rd(3); tick(); settle();
        chk("uninit_DV", {31'b0, DV}, 32'h1);
        chk("uninit_UNINIT", {31'b0, UNINIT}, 32'h1);
        chk("uninit_DO", DO, 32'h0);

        // Full write then read
        wr(5, 32'hA1B2C3D4, 4'b0000); tick(); idle();
        rd(5); tick(); settle();
        chk("full_DO", DO, 32'hA1B2C3D4);
        chk("full_DV", {31'b0, DV}, 32'h1);
        chk("full_UNINIT", {31'b0, UNINIT}, 32'h0);

        // Byte-masked write
        wr(5, 32'hFFFFFFFF, 4'b1010); tick(); idle();
        rd(5); tick(); settle();
        chk("mask_DO", DO, 32'hA1FFC3FF);

        // Read-during-write same address, per-lane write-through
        wr(7, 32'hCAFEBABE, 4'b0000); tick(); idle();
        wr(7, 32'h12345678, 4'b1100); rd(7); tick(); settle();
        chk("rdw_DO", DO, 32'hCAFE5678);
        chk("rdw_UNINIT", {31'b0, UNINIT}, 32'h0);
        rd(7); tick(); settle();
        chk("rdw_after_DO", DO, 32'hCAFE5678);

        // CSB=0: DV drops, DO holds
        tick(); settle();
        chk("hold_DV", {31'b0, DV}, 32'h0);
        chk("hold_DO", DO, 32'hCAFE5678);

        // Out-of-range read and write together
        wr(30, 32'hDEADBEEF, 4'b0000); rd(25); tick(); settle();
        chk("oor_AERR", {31'b0, AERR}, 32'h1);
        chk("oor_DO", DO, 32'h0);
        chk("oor_DV", {31'b0, DV}, 32'h1);
        chk("oor_UNINIT", {31'b0, UNINIT}, 32'h0);
        rd(5); tick(); settle();
        chk("oor_unchanged_DO", DO, 32'hA1FFC3FF);
        chk("oor_clear_AERR", {31'b0, AERR}, 32'h0);

        // Out-of-range write alone: one-cycle AERR pulse
        wr(30, 32'h0BADF00D, 4'b0000); tick(); settle();
        chk("wpulse_AERR", {31'b0, AERR}, 32'h1);
        tick(); settle();
        chk("wpulse_end_AERR", {31'b0, AERR}, 32'h0);

        // OE gates DO only
        rd(5); tick(); idle();
        repeat (LAT - 1) tick();
        OE = 0; #3;
        chk("oe_DO", DO, 32'h0);
        chk("oe_DV", {31'b0, DV}, 32'h1);
        OE = 1; #1;
        chk("oe_restore_DO", DO, 32'hA1FFC3FF);

        // Reset mid-burst of writes; the write at the reset edge is dropped
        wr(5, 32'h11111111, 4'b0000); tick();
        wr(5, 32'h22222222, 4'b0000); #1; RST = 1;
        tick(); idle();
        chk_rst("midrst");
        RST = 0;
        rd(5); tick(); settle();
        chk("postrst_UNINIT", {31'b0, UNINIT}, 32'h1);
        chk("postrst_DO", DO, 32'h0);

        // All lanes masked: written flag set, data retained across reset
        wr(5, 32'h0, 4'b1111); tick(); idle();
        rd(5); tick(); settle();
        chk("allmask_UNINIT", {31'b0, UNINIT}, 32'h0);
        chk("allmask_DO", DO, 32'h11111111);

        // Latency: DV must rise exactly LAT edges after the capture edge
        rd(5); tick(); idle();
        if (LAT == 2) begin
            #3;
            chk("lat_early_DV", {31'b0, DV}, 32'h0);
            tick();
        end
        #3;
        chk("lat_DV", {31'b0, DV}, 32'h1);
        chk("lat_DO", DO, 32'h11111111);

        tick();
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
